dot_update_queue: RTL

//  Buffers dot-position writes from the processor and replays them to the VGA controller's

---
 rtl/dot_update_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dot_update_queue.sv
// dot_update_queue: buffers processor dot writes and replays them to the VGA update port at frame starts.
// Each X then Y strobe is held HOLD clk cycles so the slower pixel clock always samples it.
module dot_update_queue #(
    parameter int DEPTH         = 16,
    parameter int ID_W          = 4,
    parameter int HOLD          = 4,
    parameter int MAX_PER_FRAME = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     proc_wEn,
    input  logic [31:0]              proc_dotID,
    input  logic [9:0]               proc_dotX,
    input  logic [8:0]               proc_dotY,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     screenEnd,
    output logic                     busy,
    output logic                     dotWren,
    output logic                     is_Yloc,
    output logic [31:0]              dotID,
    output logic [31:0]              dotLoc
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = ID_W + 19;
    localparam int HW = $clog2(HOLD + 1);
    localparam int SW = $clog2(MAX_PER_FRAME + 1);
    typedef enum logic [1:0] {IDLE, SEND_X, SEND_Y} state_t;
    state_t state, state_n;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] tail, cur, cur_n;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [SW-1:0] sent, sent_n;
    logic push, pop, se_q, frame_start, hold_done;
    logic wren_n, yloc_n;
    logic [31:0] id_n, loc_n;
    logic unused_id;
    assign unused_id   = ^proc_dotID[31:ID_W];
    assign push        = proc_wEn && !full;
    assign frame_start = screenEnd & ~se_q;
    assign hold_done   = hold_cnt == HW'(HOLD - 1);
    assign tail        = mem[rd_ptr];
    assign count_n     = count + (AW+1)'(push) - (AW+1)'(pop);
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {proc_dotID[ID_W-1:0], proc_dotX, proc_dotY};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
            count    <= count_n;
            full     <= count_n == (AW+1)'(DEPTH);
            overflow <= overflow | (proc_wEn & full);
            se_q     <= screenEnd;
        end
    end
    // State register; the output registers are loaded from their next values so they only move on transitions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            sent     <= '0;
            cur      <= '0;
            busy     <= 1'b0;
            dotWren  <= 1'b0;
            is_Yloc  <= 1'b0;
            dotID    <= '0;
            dotLoc   <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            sent     <= sent_n;
            cur      <= cur_n;
            busy     <= wren_n;
            dotWren  <= wren_n;
            is_Yloc  <= yloc_n;
            dotID    <= id_n;
            dotLoc   <= loc_n;
        end
    end
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE:    if (frame_start && count != '0) begin
                         state_n = SEND_X;
                         pop     = 1'b1;
                     end
            SEND_X:  if (hold_done) state_n = SEND_Y;
            SEND_Y:  if (hold_done) begin
                         if (count != '0 && sent < SW'(MAX_PER_FRAME)) begin
                             state_n = SEND_X;
                             pop     = 1'b1;
                         end else begin
                             state_n = IDLE;
                         end
                     end
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        hold_n = (state_n != state || state == IDLE) ? '0 : hold_cnt + HW'(1);
        sent_n = !pop ? sent : (state == IDLE ? SW'(1) : sent + SW'(1));
        cur_n  = pop ? tail : cur;
        wren_n = state_n != IDLE;
        yloc_n = state_n == SEND_Y;
        id_n   = wren_n ? 32'(cur_n[EW-1:19]) : '0;
        loc_n  = state_n == SEND_X ? 32'(cur_n[18:9]) : (yloc_n ? 32'(cur_n[8:0]) : '0);
    end
endmodule
